ram_arbiter: RTL
================

# ram_arbiter

Parametrised two-requester RAM arbiter sitting between the RAM loader, the decode core and the single-port puzzle RAM. It grants one access per cycle using a weighted priority of CORE_WEIGHT core grants per loader grant. It pauses the losing requester and routes read data back to its owner with a valid strobe. It also tracks how far the loader has filled RAM, and holds core reads of not-yet-loaded words.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 64, RAM data width
- CORE_WEIGHT, 3, consecutive core grants allowed while the loader waits (1..15)
- RAM_LAT, 1, RAM macro read latency in cycles (1 or 2)

- clk  in  1  single clock, all logic on rising edge
- resetB  in  1  asynchronous active-low reset
- ldr_ceb, ldr_web  in  1  loader request (active-low) and write enable (active-low)
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_pause  out  1  loader request not accepted this cycle; hold request
- ldr_rdata  out  DATA_W  loader read data
- ldr_rvalid  out  1  one-cycle strobe, ldr_rdata valid
- core_ceb, core_web  in  1  core request and write enable (active-low)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_pause  out  1  core request not accepted this cycle; hold request
- core_rdata  out  DATA_W  core read data
- core_rvalid  out  1  one-cycle strobe, core_rdata valid
- ram_ceb, ram_web  out  1  RAM enable and write enable (active-low, registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data
- good_addr  out  ADDR_W+1  count of contiguous words loaded from address 0

## Operation
- Request: requester drives ceb=0 with web/addr/wdata stable. The request is accepted in a cycle where its pause=0. While pause=1 the requester holds all request inputs unchanged.
- The pause outputs are combinational from the current requests and arbiter state.
- Core eligibility: a core write is always eligible. A core read is eligible only if core_addr < good_addr. An ineligible core read sees core_pause=1 regardless of loader activity.
- Grant rules:
  - Only one eligible requester: that requester is granted.
  - Both eligible: the core is granted if wcnt < CORE_WEIGHT, else the loader is granted.
  - Loser gets pause=1. With no request, there is no grant and both pause outputs are 0.
- wcnt (4 bits):
  - Increments on a core grant while the loader is requesting.
  - Clears on a loader grant, or in any cycle the loader is not requesting.
- good_addr:
  - Increments by 1 on a granted loader write with ldr_addr == good_addr[ADDR_W-1:0].
  - Saturates at 2^ADDR_W.
  - Out-of-order loader writes are performed but do not advance good_addr. Loader reads never affect it.
- Read routing:
  - Each granted read pushes an owner tag (loader/core) into a RAM_LAT+1 deep shift pipe.
  - When the tag exits, ram_rdata is registered into the owner's rdata and its rvalid pulses for one cycle.
  - The non-owner's rdata holds its previous value.
- Writes produce no rvalid.

## Timing
- Request accepted at edge t: ram_ceb/web/addr/wdata are driven from edge t+1 for exactly one cycle. ram_ceb=1 in any cycle without a grant.
- Read latency, acceptance to rvalid: RAM_LAT+2 cycles (3 for RAM_LAT=1). Back-to-back reads give back-to-back rvalids in acceptance order.
- A loader write accepted at edge t that advances good_addr updates it at edge t+1. A core read of that address becomes eligible in the cycle after edge t+1.
- Weighted pattern with both requesting continuously and all eligible: C,C,C,L,C,C,C,L,… for CORE_WEIGHT=3.
- Reset values: ram_ceb=1, ram_web=1, ram_addr=0, ram_wdata=0, ldr_rdata=0, core_rdata=0, ldr_rvalid=0, core_rvalid=0, good_addr=0, wcnt=0, tag pipe empty.
- Reset mid-operation: in-flight reads are dropped and no rvalid is issued after reset deasserts.

## Test plan
- Loader-only fill: loader writes addr 0..1023 back-to-back with data=addr.
  - good_addr steps 0→1024 and saturates.
  - ram_ceb is low every cycle, delayed one cycle from the requests.
  - ldr_pause stays 0.
- Contention with CORE_WEIGHT=3: both requesters issue writes continuously.
  - RAM access order is C,C,C,L repeating.
  - ldr_pause=1 for 3 of every 4 cycles.
  - No request is lost or duplicated (scoreboard on RAM writes).
- Read routing with RAM_LAT=1: core reads addr 5, then the loader reads addr 6 in the next cycle (good_addr=16).
  - core_rvalid fires 3 cycles after acceptance with mem[5].
  - ldr_rvalid fires one cycle later with mem[6].
  - Each rdata of the other requester is unchanged.
- Unloaded read hold: good_addr=4, core reads addr 4.
  - core_pause=1 until the loader writes addr 4.
  - The read is accepted in the cycle after good_addr becomes 5 and returns the loader's data.
- Out-of-order write: good_addr=2, loader writes addr 7.
  - The RAM write occurs and good_addr stays 2.
  - A subsequent write to addr 2 gives good_addr=3.
- Reset mid-read: assert resetB low one cycle after a core read is accepted.
  - All outputs go to their reset values.
  - No core_rvalid occurs after release.
  - The next accepted read completes normally.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of loader, core and RAM-side signals around the puzzle RAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              ldr_ceb;
    logic              ldr_web;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_pause;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_rvalid;

    logic              core_ceb;
    logic              core_web;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_pause;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;

    logic              ram_ceb;
    logic              ram_web;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [ADDR_W:0]   good_addr;

    modport slave (
        input  ldr_ceb, ldr_web, ldr_addr, ldr_wdata,
        output ldr_pause, ldr_rdata, ldr_rvalid,
        input  core_ceb, core_web, core_addr, core_wdata,
        output core_pause, core_rdata, core_rvalid,
        output ram_ceb, ram_web, ram_addr, ram_wdata,
        input  ram_rdata,
        output good_addr
    );

    modport master (
        output ldr_ceb, ldr_web, ldr_addr, ldr_wdata,
        input  ldr_pause, ldr_rdata, ldr_rvalid,
        output core_ceb, core_web, core_addr, core_wdata,
        input  core_pause, core_rdata, core_rvalid,
        input  ram_ceb, ram_web, ram_addr, ram_wdata,
        output ram_rdata,
        input  good_addr
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port puzzle RAM: weighted core/loader grants,
// owner-tagged read-data routing, and tracking of the contiguously loaded region.
module ram_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int CORE_WEIGHT = 3,
    parameter int RAM_LAT     = 1
) (
    input logic          clk,
    input logic          resetB,
    ram_arbiter_if.slave bus
);
    localparam int              PIPE_D   = RAM_LAT + 1;
    localparam logic [3:0]      WEIGHT   = 4'(CORE_WEIGHT);
    localparam logic [3:0]      WCNT_ONE = 4'd1;
    localparam logic [ADDR_W:0] GOOD_ONE = (ADDR_W+1)'(1);

    logic              w_ldrReq;
    logic              w_coreReq;
    logic              w_coreElig;
    logic              w_grantCore;
    logic              w_grantLdr;
    logic              w_grantAny;
    logic              w_grantRead;
    logic              w_goodAdvance;
    logic              w_selWeb;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;

    logic [3:0]        r_wcnt;
    logic [ADDR_W:0]   r_goodAddr;
    logic              r_ramCeb;
    logic              r_ramWeb;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [DATA_W-1:0] r_ramWdata;
    logic [PIPE_D-1:0] r_tagValid;
    logic [PIPE_D-1:0] r_tagCore;
    logic              r_ldrRvalid;
    logic              r_coreRvalid;
    logic [DATA_W-1:0] r_ldrRdata;
    logic [DATA_W-1:0] r_coreRdata;

    // Core reads of words beyond the loaded region are held off entirely, so the
    // loader wins by default while such a read is pending.
    always_comb begin
        w_ldrReq      = ~bus.ldr_ceb;
        w_coreReq     = ~bus.core_ceb;
        w_coreElig    = w_coreReq & (~bus.core_web | ({1'b0, bus.core_addr} < r_goodAddr));
        w_grantCore   = w_coreElig & (~w_ldrReq | (r_wcnt < WEIGHT));
        w_grantLdr    = w_ldrReq & ~w_grantCore;
        w_grantAny    = w_grantCore | w_grantLdr;
        w_selWeb      = w_grantCore ? bus.core_web   : bus.ldr_web;
        w_selAddr     = w_grantCore ? bus.core_addr  : bus.ldr_addr;
        w_selWdata    = w_grantCore ? bus.core_wdata : bus.ldr_wdata;
        w_grantRead   = w_grantAny & w_selWeb;
        w_goodAdvance = w_grantLdr & ~bus.ldr_web & ~r_goodAddr[ADDR_W]
                      & (bus.ldr_addr == r_goodAddr[ADDR_W-1:0]);
    end

    assign bus.ldr_pause  = w_ldrReq & ~w_grantLdr;
    assign bus.core_pause = w_coreReq & ~w_grantCore;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_wcnt <= '0;
        end else if (!w_ldrReq || w_grantLdr) begin
            r_wcnt <= '0;
        end else if (w_grantCore) begin
            r_wcnt <= r_wcnt + WCNT_ONE;
        end
    end

    // The top bit set means every word is loaded; the count stops there.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_goodAddr <= '0;
        end else if (w_goodAdvance) begin
            r_goodAddr <= r_goodAddr + GOOD_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_ramCeb   <= 1'b1;
            r_ramWeb   <= 1'b1;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
        end else if (w_grantAny) begin
            r_ramCeb   <= 1'b0;
            r_ramWeb   <= w_selWeb;
            r_ramAddr  <= w_selAddr;
            r_ramWdata <= w_selWdata;
        end else begin
            r_ramCeb   <= 1'b1;
            r_ramWeb   <= 1'b1;
        end
    end

    // The tag leaves the pipe exactly when the RAM presents the matching read word.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_tagValid   <= '0;
            r_tagCore    <= '0;
            r_ldrRvalid  <= 1'b0;
            r_coreRvalid <= 1'b0;
            r_ldrRdata   <= '0;
            r_coreRdata  <= '0;
        end else begin
            r_tagValid   <= {r_tagValid[PIPE_D-2:0], w_grantRead};
            r_tagCore    <= {r_tagCore[PIPE_D-2:0], w_grantCore};
            r_ldrRvalid  <= r_tagValid[PIPE_D-1] & ~r_tagCore[PIPE_D-1];
            r_coreRvalid <= r_tagValid[PIPE_D-1] & r_tagCore[PIPE_D-1];
            if (r_tagValid[PIPE_D-1] && r_tagCore[PIPE_D-1]) begin
                r_coreRdata <= bus.ram_rdata;
            end
            if (r_tagValid[PIPE_D-1] && !r_tagCore[PIPE_D-1]) begin
                r_ldrRdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_ceb     = r_ramCeb;
    assign bus.ram_web     = r_ramWeb;
    assign bus.ram_addr    = r_ramAddr;
    assign bus.ram_wdata   = r_ramWdata;
    assign bus.ldr_rvalid  = r_ldrRvalid;
    assign bus.core_rvalid = r_coreRvalid;
    assign bus.ldr_rdata   = r_ldrRdata;
    assign bus.core_rdata  = r_coreRdata;
    assign bus.good_addr   = r_goodAddr;
endmodule
